inst_supply: RTL and testbench

//  Read-only instruction cache between the fetch stage and the tagged memory port.

---
 rtl/inst_supply.sv | 202 ++++++++++++++++++++
 tb/tb_inst_supply.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_supply.sv
// Read-only instruction cache: returns up to WIDTH consecutive words from pc,
// tracks up to two outstanding block loads, and forwards answers same-cycle.
module inst_supply #(
  parameter int SIZE  = 8,
  parameter int BANK  = 2,
  parameter int WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_enable,
  input  logic [31:0]            fetch_pc,
  output logic [WIDTH-1:0][31:0] fetch_data,
  output logic [WIDTH-1:0]       fetch_valid,
  output logic [1:0]             mem_qry_cmd,
  output logic [31:0]            mem_qry_addr,
  input  logic [3:0]             mem_ack,
  input  logic [3:0]             mem_ans_tag,
  input  logic [63:0]            mem_ans_blk,
  output logic                   evict_valid,
  output logic [31:0]            evict_addr,
  output logic [63:0]            evict_blk
);
  localparam int SETS = SIZE / BANK;
  localparam int SB   = $clog2(SETS);
  localparam int TW   = 29 - SB;
  localparam int AW   = (BANK > 1) ? $clog2(BANK) : 1;

  // per-way age within a set: 0 = most recent, BANK-1 = replacement victim
  typedef logic [BANK-1:0][AW-1:0] age_t;

  logic [BANK-1:0] line_v   [SETS];
  logic [TW-1:0]   line_tag [SETS][BANK];
  logic [63:0]     line_dat [SETS][BANK];
  age_t            lru      [SETS];
  age_t            lru_n    [SETS];

  logic [1:0]      trk_busy;
  logic [1:0]      trk_acked;
  logic [3:0]      trk_tag  [2];
  logic [28:0]     trk_blk  [2];
  logic            trk_old;

  logic [31:0]     pc_last;
  logic [28:0]     nb       [2];
  logic [1:0]      need;
  logic [1:0]      hit;
  logic [AW-1:0]   hway     [2];
  logic [63:0]     hdat     [2];

  logic            ans_hit;
  logic            ans_idx;
  logic [28:0]     ans_blk;
  logic [SB-1:0]   fset;
  logic [AW-1:0]   vway;

  logic            q_act;
  logic            q_idx;
  logic            alloc;
  logic [28:0]     alloc_blk;
  logic            free_idx;

  function automatic age_t touch(age_t a, logic [AW-1:0] w);
    age_t r;
    r = a;
    for (int v = 0; v < BANK; v++)
      if (a[v] < a[w]) r[v] = a[v] + 1'b1;
    r[w] = '0;
    return r;
  endfunction

  // the two blocks a fetch can span, and their cache lookups
  always_comb begin
    pc_last = fetch_pc + 32'(4 * (WIDTH - 1));
    nb[0]   = fetch_pc[31:3];
    nb[1]   = pc_last[31:3];
    need[0] = fetch_enable;
    need[1] = fetch_enable && (nb[1] != nb[0]);
    for (int n = 0; n < 2; n++) begin
      hit[n]  = 1'b0;
      hway[n] = '0;
      hdat[n] = '0;
      for (int w = 0; w < BANK; w++)
        if (line_v[nb[n][SB-1:0]][w] && line_tag[nb[n][SB-1:0]][w] == nb[n][28:SB]) begin
          hit[n]  = 1'b1;
          hway[n] = AW'(w);
          hdat[n] = line_dat[nb[n][SB-1:0]][w];
        end
    end
  end

  // answer matching against acked trackers, and the way it will fill
  always_comb begin
    ans_hit = 1'b0;
    ans_idx = 1'b0;
    for (int t = 1; t >= 0; t--)
      if (mem_ans_tag != 4'd0 && trk_busy[t] && trk_acked[t] && trk_tag[t] == mem_ans_tag) begin
        ans_hit = 1'b1;
        ans_idx = 1'(t);
      end
    ans_blk = trk_blk[ans_idx];
    fset    = ans_blk[SB-1:0];
    vway    = '0;
    for (int w = 0; w < BANK; w++)
      if (lru[fset][w] == AW'(BANK - 1)) vway = AW'(w);
    for (int w = BANK - 1; w >= 0; w--)
      if (!line_v[fset][w]) vway = AW'(w);
  end

  // per-slot data select with prefix-valid chaining
  always_comb begin
    logic [31:0] a;
    logic [28:0] sb;
    logic [63:0] blk;
    logic        ok;
    logic        sel;
    ok = reset && fetch_enable;
    for (int i = 0; i < WIDTH; i++) begin
      a   = fetch_pc + 32'(4 * i);
      sb  = a[31:3];
      sel = (sb != nb[0]);
      blk = hit[sel] ? hdat[sel] : mem_ans_blk;
      ok  = ok && (hit[sel] || (ans_hit && ans_blk == sb));
      fetch_valid[i] = ok;
      fetch_data[i]  = ok ? (a[2] ? blk[31:0] : blk[63:32]) : 32'd0;
    end
  end

  // query the oldest tracker still waiting for an ack
  always_comb begin
    q_act = 1'b0;
    q_idx = trk_old;
    if (trk_busy[trk_old] && !trk_acked[trk_old]) begin
      q_act = 1'b1;
      q_idx = trk_old;
    end else if (trk_busy[~trk_old] && !trk_acked[~trk_old]) begin
      q_act = 1'b1;
      q_idx = ~trk_old;
    end
    mem_qry_cmd  = (reset && q_act) ? 2'd1 : 2'd0;
    mem_qry_addr = (reset && q_act) ? {trk_blk[q_idx], 3'b000} : 32'd0;
  end

  // new tracker for the lowest needed block that is missing and untracked
  always_comb begin
    alloc     = 1'b0;
    alloc_blk = nb[0];
    free_idx  = trk_busy[0];
    for (int n = 1; n >= 0; n--)
      if (need[n] && !hit[n] && !(ans_hit && ans_blk == nb[n]) &&
          !(trk_busy[0] && trk_blk[0] == nb[n]) && !(trk_busy[1] && trk_blk[1] == nb[n])) begin
        alloc     = 1'b1;
        alloc_blk = nb[n];
      end
    if (&trk_busy) alloc = 1'b0;
  end

  // recency update order: fill, then block B+1, then block B
  always_comb begin
    for (int s = 0; s < SETS; s++) lru_n[s] = lru[s];
    if (ans_hit) lru_n[fset] = touch(lru_n[fset], vway);
    for (int n = 1; n >= 0; n--)
      if (need[n] && hit[n] && !(ans_hit && fset == nb[n][SB-1:0] && vway == hway[n]))
        lru_n[nb[n][SB-1:0]] = touch(lru_n[nb[n][SB-1:0]], hway[n]);
  end

  // cache lines, recency and tracker state
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        line_v[s] <= '0;
        for (int w = 0; w < BANK; w++) lru[s][w] <= AW'(w);
      end
      trk_busy  <= '0;
      trk_acked <= '0;
      trk_old   <= 1'b0;
    end else begin
      for (int s = 0; s < SETS; s++) lru[s] <= lru_n[s];
      if (q_act && mem_ack != 4'd0) begin
        trk_acked[q_idx] <= 1'b1;
        trk_tag[q_idx]   <= mem_ack;
      end
      if (ans_hit) begin
        trk_busy[ans_idx]      <= 1'b0;
        trk_acked[ans_idx]     <= 1'b0;
        line_v[fset][vway]     <= 1'b1;
        line_tag[fset][vway]   <= ans_blk[28:SB];
        line_dat[fset][vway]   <= mem_ans_blk;
      end
      if (alloc) begin
        trk_busy[free_idx]  <= 1'b1;
        trk_acked[free_idx] <= 1'b0;
        trk_blk[free_idx]   <= alloc_blk;
        trk_old             <= trk_busy[~free_idx] ? ~free_idx : free_idx;
      end
    end
  end

  assign evict_valid = 1'b0;
  assign evict_addr  = 32'd0;
  assign evict_blk   = 64'd0;

endmodule

// File: tb/tb_inst_supply.sv
// Bench for inst_supply: directed steps then randomized traffic, all checked
// against a recency-list cache model and a sequence-ordered tracker model.
module tb_inst_supply;
  localparam int W    = 3;
  localparam int SETS = 4;
  localparam int BANK = 2;

  logic              clock;
  logic              rst;
  logic              en;
  logic [31:0]       pc;
  logic [W-1:0][31:0] fetch_data;
  logic [W-1:0]      fetch_valid;
  logic [1:0]        mem_qry_cmd;
  logic [31:0]       mem_qry_addr;
  logic [3:0]        mem_ack;
  logic [3:0]        mem_ans_tag;
  logic [63:0]       mem_ans_blk;
  logic              evict_valid;
  logic [31:0]       evict_addr;
  logic [63:0]       evict_blk;

  inst_supply #(.SIZE(8), .BANK(BANK), .WIDTH(W)) dut (
    .clock(clock), .reset(rst), .fetch_enable(en), .fetch_pc(pc),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .mem_qry_cmd(mem_qry_cmd), .mem_qry_addr(mem_qry_addr),
    .mem_ack(mem_ack), .mem_ans_tag(mem_ans_tag), .mem_ans_blk(mem_ans_blk),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_blk(evict_blk)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nmis = 0;

  // model: all cached blocks in one list, most recent first
  logic [28:0] mru[$];
  logic [63:0] mdata [logic [28:0]];
  bit          mt_busy  [2];
  bit          mt_acked [2];
  logic [3:0]  mt_tag   [2];
  logic [28:0] mt_blk   [2];
  int          mt_seq   [2];
  int          seqc = 0;
  int          tagc = 0;
  logic [W-1:0] last_valid;

  typedef struct {
    logic [3:0]  tag;
    logic [28:0] blk;
  } out_t;
  out_t outs[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memfn(input logic [28:0] b);
    return {32'(b) * 32'h9e3779b1, 32'(b) ^ 32'hc0ffee00};
  endfunction

  function automatic bit in_cache(input logic [28:0] b);
    foreach (mru[k]) if (mru[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic touch(input logic [28:0] b);
    for (int k = 0; k < mru.size(); k++)
      if (mru[k] == b) begin
        mru.delete(k);
        break;
      end
    mru.push_front(b);
  endtask

  task automatic fill(input logic [28:0] b);
    int cnt;
    int last;
    cnt = 0;
    last = -1;
    foreach (mru[k])
      if (mru[k] % SETS == b % SETS) begin
        cnt++;
        last = k;
      end
    if (cnt >= BANK) mru.delete(last);
    mru.push_front(b);
  endtask

  task automatic mq(output bit qa, output int qi);
    qa = 0;
    qi = 0;
    for (int t = 0; t < 2; t++)
      if (mt_busy[t] && !mt_acked[t] && (!qa || mt_seq[t] < mt_seq[qi])) begin
        qa = 1;
        qi = t;
      end
  endtask

  task automatic set_in(input bit e, input logic [31:0] p, input logic [3:0] ack,
                        input logic [3:0] tag, input logic [63:0] blk);
    en = e;
    pc = p;
    mem_ack = ack;
    mem_ans_tag = tag;
    mem_ans_blk = blk;
  endtask

  // one clock: check outputs against the model, then advance the model
  task automatic cycle();
    bit amatch, qa, prev, avail, hitb, doalloc;
    int aidx, qi, fidx;
    logic [W-1:0] ev;
    logic [31:0] ed [W];
    logic [31:0] a;
    logic [28:0] b, newblk;
    logic [63:0] blk;
    logic [28:0] nbk[$];
    bit nhit[$];
    #1;
    amatch = 0;
    aidx = 0;
    if (rst)
      for (int t = 0; t < 2; t++)
        if (!amatch && mt_busy[t] && mt_acked[t] && mem_ans_tag != 0 && mt_tag[t] == mem_ans_tag) begin
          amatch = 1;
          aidx = t;
        end
    prev = 1;
    for (int i = 0; i < W; i++) begin
      a = pc + 4 * i;
      b = a[31:3];
      hitb = in_cache(b);
      blk = hitb ? mdata[b] : mem_ans_blk;
      avail = hitb || (amatch && mt_blk[aidx] == b);
      prev = prev && rst && en && avail;
      ev[i] = prev;
      ed[i] = prev ? (a[2] ? blk[31:0] : blk[63:32]) : 32'd0;
      if (rst && en && (nbk.size() == 0 || nbk[nbk.size()-1] != b)) begin
        nbk.push_back(b);
        nhit.push_back(hitb);
      end
    end
    mq(qa, qi);
    chk("valid", 64'(fetch_valid), 64'(ev));
    for (int i = 0; i < W; i++) chk($sformatf("data%0d", i), 64'(fetch_data[i]), 64'(ed[i]));
    chk("qry_cmd", 64'(mem_qry_cmd), (rst && qa) ? 64'd1 : 64'd0);
    chk("qry_addr", 64'(mem_qry_addr), (rst && qa) ? 64'({mt_blk[qi], 3'b000}) : 64'd0);
    chk("evict", 64'({evict_valid, |evict_addr, |evict_blk}), 64'd0);
    last_valid = fetch_valid;

    if (!rst) begin
      mru.delete();
      for (int t = 0; t < 2; t++) begin
        mt_busy[t] = 0;
        mt_acked[t] = 0;
      end
    end else begin
      doalloc = 0;
      newblk = '0;
      fidx = mt_busy[0] ? 1 : 0;
      if (!(mt_busy[0] && mt_busy[1]))
        foreach (nbk[n])
          if (!doalloc && !nhit[n] && !(amatch && mt_blk[aidx] == nbk[n]) &&
              !(mt_busy[0] && mt_blk[0] == nbk[n]) && !(mt_busy[1] && mt_blk[1] == nbk[n])) begin
            doalloc = 1;
            newblk = nbk[n];
          end
      if (qa && mem_ack != 0) begin
        mt_acked[qi] = 1;
        mt_tag[qi] = mem_ack;
      end
      if (amatch) begin
        fill(mt_blk[aidx]);
        mdata[mt_blk[aidx]] = mem_ans_blk;
        mt_busy[aidx] = 0;
        mt_acked[aidx] = 0;
      end
      for (int n = nbk.size() - 1; n >= 0; n--)
        if (nhit[n] && in_cache(nbk[n])) touch(nbk[n]);
      if (doalloc) begin
        seqc++;
        mt_busy[fidx] = 1;
        mt_acked[fidx] = 0;
        mt_blk[fidx] = newblk;
        mt_seq[fidx] = seqc;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // random memory side: answers outstanding tags out of order, acks queries
  task automatic drive_mem();
    bit qa;
    int qi, k;
    out_t o;
    mem_ack = 0;
    mem_ans_tag = 0;
    mem_ans_blk = {$urandom, $urandom};
    if (outs.size() > 0 && $urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, outs.size() - 1);
      mem_ans_tag = outs[k].tag;
      mem_ans_blk = memfn(outs[k].blk);
      outs.delete(k);
    end
    mq(qa, qi);
    if (rst && qa && $urandom_range(0, 1) == 1) begin
      tagc = (tagc % 15) + 1;
      mem_ack = 4'(tagc);
      o.tag = 4'(tagc);
      o.blk = mt_blk[qi];
      outs.push_back(o);
    end
  endtask

  task automatic fetch_until(input logic [31:0] p);
    bit done;
    done = 0;
    en = 1;
    pc = p;
    for (int c = 0; c < 200 && !done; c++) begin
      drive_mem();
      cycle();
      done = (last_valid == 3'b111);
    end
    chk("fill_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    rst = 0;
    set_in(1, 32'h0, 0, 0, 0);
    @(negedge clock);
    cycle();
    cycle();
    rst = 1;

    // miss on pc 0: two trackers, queries held until acked
    set_in(1, 32'h0, 0, 0, 0);
    cycle();
    #1;
    chk("t1_cmd", 64'(mem_qry_cmd), 64'd1);
    chk("t1_addr", 64'(mem_qry_addr), 64'h0);
    chk("t1_valid", 64'(fetch_valid), 64'd0);
    cycle();
    set_in(1, 32'h0, 4'd1, 0, 0);
    cycle();
    set_in(1, 32'h0, 0, 0, 0);
    #1;
    chk("t2_addr", 64'(mem_qry_addr), 64'h8);
    cycle();
    set_in(1, 32'h0, 4'd2, 0, 0);
    #1;
    chk("t2_held", 64'(mem_qry_addr), 64'h8);
    cycle();
    set_in(1, 32'h0, 0, 0, 0);
    #1;
    chk("t2_none", 64'(mem_qry_cmd), 64'd0);
    chk("t2_valid", 64'(fetch_valid), 64'd0);
    cycle();

    // answers forwarded same cycle
    set_in(1, 32'h0, 0, 4'd1, 64'hdeadbeefcc00ffee);
    #1;
    chk("t3_valid", 64'(fetch_valid), 64'b011);
    chk("t3_d0", 64'(fetch_data[0]), 64'hdeadbeef);
    chk("t3_d1", 64'(fetch_data[1]), 64'hcc00ffee);
    chk("t3_d2", 64'(fetch_data[2]), 64'h0);
    cycle();
    set_in(1, 32'h0, 0, 4'd2, 64'h12345678ffffffff);
    #1;
    chk("t4_valid", 64'(fetch_valid), 64'b111);
    chk("t4_d2", 64'(fetch_data[2]), 64'h12345678);
    cycle();
    set_in(1, 32'h0, 0, 0, 64'h0);
    #1;
    chk("t4_hit", 64'(fetch_valid), 64'b111);
    chk("t4_cmd", 64'(mem_qry_cmd), 64'd0);
    cycle();
    set_in(1, 32'h4, 0, 0, 64'h0);
    #1;
    chk("t5_valid", 64'(fetch_valid), 64'b111);
    chk("t5_d0", 64'(fetch_data[0]), 64'hcc00ffee);
    chk("t5_d1", 64'(fetch_data[1]), 64'h12345678);
    chk("t5_d2", 64'(fetch_data[2]), 64'hffffffff);
    chk("t5_cmd", 64'(mem_qry_cmd), 64'd0);
    cycle();

    // three blocks into one set evicts the least recent
    fetch_until(32'h20);
    fetch_until(32'h40);
    set_in(1, 32'h0, 0, 0, 0);
    #1;
    chk("t6_evicted", 64'(fetch_valid), 64'd0);
    cycle();
    #1;
    chk("t6_refetch", 64'(mem_qry_addr), 64'h0);
    cycle();
    fetch_until(32'h0);

    // reset while a miss is acked; the stale answer must be ignored
    set_in(1, 32'h100, 0, 0, 0);
    cycle();
    set_in(1, 32'h100, 4'd5, 0, 0);
    #1;
    chk("t7_qry", 64'(mem_qry_addr), 64'h100);
    cycle();
    rst = 0;
    outs.delete();
    set_in(1, 32'h100, 0, 0, 0);
    #1;
    chk("t7_rst_valid", 64'(fetch_valid), 64'd0);
    cycle();
    rst = 1;
    set_in(1, 32'h100, 0, 4'd5, 64'h0badf00d0badf00d);
    #1;
    chk("t7_stale", 64'(fetch_valid), 64'd0);
    cycle();
    fetch_until(32'h100);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) pc = 32'($urandom_range(0, 63)) * 4;
      drive_mem();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
